// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner: column drive, synchronized row sense, debounce,
// linear key-code encoding and a small output FIFO with valid/ready pop.
module keypad_scan_fifo #(
    parameter int unsigned NUM_COLS     = 4,
    parameter int unsigned NUM_ROWS     = 3,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CODE_W       = $clog2(NUM_COLS * NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] in_from_keypad,
    output logic [NUM_COLS-1:0] out_to_keypad,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                overflow,
    input  logic                overflow_clr
);
    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned MCH_W = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [NUM_ROWS-1:0] sync1;
    logic [NUM_ROWS-1:0] rs;
    logic [DIV_W-1:0]    dwell;
    logic                sample;

    logic [1:0]          state, state_next;
    logic [MCH_W-1:0]    match, match_next;
    logic [ROW_W-1:0]    row_q, row_next;
    logic [COL_W-1:0]    col_idx, col_next;
    logic [ROW_W-1:0]    low_row;
    logic                any_low;
    logic                push;
    logic                advance;
    logic [CODE_W-1:0]   push_code;

    logic [CODE_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [OCC_W-1:0]    occ, occ_next;
    logic                pop, full, push_ok, drop;

    assign sample    = (dwell == DIV_W'(SCAN_DIV - 1));
    assign any_low   = ~&rs;
    assign push_code = CODE_W'(col_idx) * CODE_W'(NUM_ROWS) + CODE_W'(row_q);

    // Lowest-indexed low row wins when several rows are pressed.
    always_comb begin
        low_row = '0;
        for (int r = int'(NUM_ROWS) - 1; r >= 0; r--) begin
            if (!rs[r]) low_row = ROW_W'(r);
        end
    end

    // Next-state logic; match counts press samples in DEBOUNCE and clean release samples in HELD.
    always_comb begin
        state_next = state;
        match_next = match;
        row_next   = row_q;
        push       = 1'b0;
        advance    = 1'b0;
        if (sample) begin
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        row_next   = low_row;
                        match_next = MCH_W'(1);
                        state_next = ST_DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!rs[row_q]) begin
                        if (match == MCH_W'(DEBOUNCE_CNT - 1)) begin
                            push       = 1'b1;
                            match_next = '0;
                            state_next = ST_HELD;
                        end else begin
                            match_next = match + MCH_W'(1);
                        end
                    end else begin
                        state_next = ST_SCAN;
                        advance    = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (any_low) begin
                        match_next = '0;
                    end else if (match == MCH_W'(DEBOUNCE_CNT - 1)) begin
                        match_next = '0;
                        state_next = ST_SCAN;
                        advance    = 1'b1;
                    end else begin
                        match_next = match + MCH_W'(1);
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end
        col_next = col_idx;
        if (advance) col_next = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + COL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SCAN;
            match <= '0;
            row_q <= '0;
        end else begin
            state <= state_next;
            match <= match_next;
            row_q <= row_next;
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign pop      = key_valid && key_ready;
    assign full     = (occ == OCC_W'(FIFO_DEPTH));
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_next  = rd_ptr + PTR_W'(pop);
    assign occ_next = occ + OCC_W'(push_ok) - OCC_W'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= '1;
            rs            <= '1;
            dwell         <= '0;
            col_idx       <= '0;
            out_to_keypad <= ~(NUM_COLS'(1));
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            key_valid     <= 1'b0;
            key_code      <= '0;
            overflow      <= 1'b0;
        end else begin
            sync1         <= in_from_keypad;
            rs            <= sync1;
            dwell         <= sample ? '0 : dwell + DIV_W'(1);
            col_idx       <= col_next;
            out_to_keypad <= ~(NUM_COLS'(1) << col_next);
            wr_ptr        <= wr_ptr + PTR_W'(push_ok);
            rd_ptr        <= rd_next;
            occ           <= occ_next;
            key_valid     <= (occ_next != '0);
            // Head comes straight from the push when nothing older remains.
            if (push_ok && ((occ - OCC_W'(pop)) == '0)) key_code <= push_code;
            else                                         key_code <= mem[rd_next];
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised keypad scanner: drives active-low one-hot columns and samples active-low rows through a 2-flop synchronizer.
- Debounces each press, encodes it as a linear key code, and buffers codes in a small FIFO with a valid/ready output handshake.
- Replaces ad-hoc scan logic in top. Feeds the key consumer (digit entry / MLP input controller) and can be reused for any NUM_COLS x NUM_ROWS matrix.

Parameters:
NUM_COLS, 4, number of column drive lines
NUM_ROWS, 3, number of row sense lines
SCAN_DIV, 1000, clocks each column is held (dwell); must be >= 4
DEBOUNCE_CNT, 4, consecutive matching samples needed to accept a press or a release; must be >= 2
FIFO_DEPTH, 4, key-code buffer entries; power of two, >= 2
CODE_W, $clog2(NUM_COLS*NUM_ROWS), key code width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_from_keypad  in  NUM_ROWS  row lines, active-low (idle all ones)
out_to_keypad  out  NUM_COLS  column drive, active-low one-hot
key_code  out  CODE_W  code at the FIFO head
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts the head when key_valid && key_ready
overflow  out  1  sticky: a debounced press was dropped because the FIFO was full
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (sync, rst=1 at posedge):
  - out_to_keypad = all ones with bit0 low (4'b1110 at defaults).
  - Dwell counter = 0; FSM = SCAN; FIFO empty; key_valid=0; key_code=0; overflow=0.
  - Synchronizer flops = all ones.
- Reset mid-operation discards the FIFO contents and any press in progress.
- Rows pass through a 2-flop synchronizer (rs). A sample point is the cycle where the dwell counter = SCAN_DIV-1; the counter wraps to 0 there.
- Key code = col_idx*NUM_ROWS + row_idx, both 0-based, row_idx = bit index of the low row.
  - If several rows are low, the lowest index wins.
- FSM:
  - SCAN: at each sample point, if rs has any bit 0:
    - latch col_idx/row_idx, set match count = 1, go to DEBOUNCE;
    - the column does not advance.
  - SCAN, otherwise: rotate the low bit left, wrapping col NUM_COLS-1 -> 0.
  - DEBOUNCE: the column is frozen. At each sample point:
    - if rs[row_idx]=0, increment the match count;
    - when the count reaches DEBOUNCE_CNT, push the code and go to HELD;
    - if rs[row_idx]=1, go to SCAN and advance the column.
  - HELD: the column is frozen. At each sample point:
    - count consecutive samples with rs all ones; any low bit resets the count;
    - at DEBOUNCE_CNT, go to SCAN and advance the column.
  - A key held down produces exactly one code (no auto-repeat).
- FIFO and handshake:
  - Push occurs on the sample-point cycle. key_valid/key_code reflect the new entry on the next cycle when the FIFO was empty.
  - Pop when key_valid && key_ready. key_code is stable while key_valid=1 and key_ready=0.
  - Push and pop in the same cycle: both happen, count unchanged, ordering preserved. This includes the full case, where the push succeeds because a slot frees.
  - Push when full with no pop: the code is dropped and overflow is set next cycle.
- overflow: stays 1 until overflow_clr=1. If overflow_clr and a new drop coincide, the set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty use an extra occupancy count (0..FIFO_DEPTH).
- No combinational path from in_from_keypad to any output.

Test Plan:
Use SCAN_DIV=8, DEBOUNCE_CNT=3, FIFO_DEPTH=4 unless noted.
1. Idle scan: rst=1 for 2 clks, then rows=3'b111 -> out_to_keypad sequence 1110,1101,1011,0111,1110, changing every 8 clks; key_valid stays 0.
2. Single press: while out_to_keypad=1110, drive rows 3'b110 for 60 clks, then release -> exactly one pop of key_code=0; column frozen at 1110 until 3 clean release samples.
3. Keys '5' (col1, rows 101) and '9' (col2, rows 011) with key_ready=0 -> FIFO holds codes 4 then 8; raise key_ready -> 4 then 8 on consecutive cycles, then key_valid=0.
4. Bounce: rows=110 for 1 sample, 111 for 1 sample, 110 again, on col0 -> no push from the first contact; single code 0 after 3 stable samples.
5. Overflow: with key_ready=0, press 5 distinct keys -> first 4 codes retained in order, overflow=1 after the 5th. Pulse overflow_clr -> overflow=0. Then pop with key_ready=1 while a 6th press pushes in the same cycle -> no drop, overflow stays 0.
6. Reset mid-press: in DEBOUNCE with match count=2, assert rst -> out_to_keypad=1110, key_valid=0, no code emitted; multi-row press rows=3'b100 on col3 -> code 9 (lowest row wins).
